alu_control_md: RTL and testbench

ALU_CONTROL_MD -- requirements
Module: alu_control_md

---
 rtl/alu_control_md.sv | 136 +++++++++++++
 tb/tb_alu_control_md.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_control_md.sv
// ALU control decoder with multi-cycle M-extension sequencing.
// Fast ops pulse out_valid the next cycle; MUL/DIV ops stall upstream for a fixed count first.
module alu_control_md #(
  parameter int XLEN       = 64,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = XLEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] alu_op,
  input  logic [6:0] inst_opcode,
  input  logic [2:0] inst_funct3,
  input  logic       inst_bit30,
  input  logic       inst_bit25,
  input  logic       flush,
  output logic [5:0] alu_function,
  output logic       out_valid,
  output logic       stall,
  output logic       md_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic       IS64     = (XLEN == 64);
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state;
  logic [5:0] cnt;
  logic [6:0] dec;
  logic       md_req;
  logic [5:0] dec_func;
  logic [5:0] load;

  // Returns {multi-cycle request, 6-bit function code}.
  function automatic logic [6:0] decode(input logic [1:0] op, input logic [6:0] opc,
                                        input logic [2:0] f3, input logic b30, input logic b25);
    logic       md;
    logic       word;
    logic       sec;
    logic [5:0] f;
    md   = b25 && ((opc == 7'b0110011) || ((opc == 7'b0111011) && IS64));
    word = ((opc == 7'b0011011) || (opc == 7'b0111011)) && IS64;
    sec  = !md && b30 && ((f3 == 3'b000) || (f3 == 3'b101));
    case (op)
      2'b00: f = 6'b000000;
      2'b01: f = 6'b001000;
      2'b10: f = {md, word, sec, f3};
      2'b11: begin
        case (f3)
          3'b000, 3'b001: f = 6'b001000;
          3'b100, 3'b101: f = 6'b001010;
          3'b110, 3'b111: f = 6'b001011;
          default:        f = 6'b001000;
        endcase
      end
      default: f = 6'b000000;
    endcase
    return {(op == 2'b10) && md, f};
  endfunction

  // Combinational decode of the presented instruction.
  always_comb begin
    dec      = decode(alu_op, inst_opcode, inst_funct3, inst_bit30, inst_bit25);
    md_req   = dec[6];
    dec_func = dec[5:0];
    if (inst_funct3[2]) begin
      load = DIV_LOAD;
    end else begin
      load = MUL_LOAD;
    end
  end

  // Sequencer: flush dominates; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 6'd0;
      alu_function <= 6'd0;
      out_valid    <= 1'b0;
      stall        <= 1'b0;
      md_busy      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      out_valid <= 1'b0;
      stall     <= 1'b0;
      md_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            alu_function <= dec_func;
            if (md_req) begin
              cnt     <= load;
              state   <= BUSY;
              stall   <= 1'b1;
              md_busy <= 1'b1;
            end else begin
              out_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          out_valid <= 1'b0;
          if (cnt == 6'd0) begin
            state     <= DONE;
            stall     <= 1'b0;
            md_busy   <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cnt       <= 6'd0;
          out_valid <= 1'b0;
          stall     <= 1'b0;
          md_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: decode vectors, MUL/DIV timing, flush and async reset.
module tb_alu_control_md;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_valid32 = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [6:0] opc = 7'b0000000;
  logic [2:0] f3 = 3'b000;
  logic       b30 = 1'b0;
  logic       b25 = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] func64, func32;
  logic       ov64, ov32, st64, st32, mb64, mb32;
  int         checks = 0;
  int         errors = 0;
  int         n;

  always #5 clk = ~clk;

  alu_control_md dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_op(alu_op), .inst_opcode(opc),
    .inst_funct3(f3), .inst_bit30(b30), .inst_bit25(b25), .flush(flush),
    .alu_function(func64), .out_valid(ov64), .stall(st64), .md_busy(mb64)
  );

  alu_control_md #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .alu_op(alu_op), .inst_opcode(opc),
    .inst_funct3(f3), .inst_bit30(b30), .inst_bit25(b25), .flush(flush),
    .alu_function(func32), .out_valid(ov32), .stall(st32), .md_busy(mb32)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [1:0] op, input logic [6:0] o, input logic [2:0] f,
                     input logic x30, input logic x25);
    alu_op = op; opc = o; f3 = f; b30 = x30; b25 = x25;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept the presented md op and count stall cycles up to DONE (bounded).
  task automatic run_md(input string tag, input int exp_n, input logic [5:0] exp_f, input logic hold);
    in_valid = 1'b1;
    tick();
    if (hold) alu_op = 2'b00;
    else in_valid = 1'b0;
    chk({tag, "_md_busy"}, {7'd0, mb64}, 8'd1);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (!st64) break;
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, 8'(n), 8'(exp_n));
    chk({tag, "_done_valid"}, {7'd0, ov64}, 8'd1);
    chk({tag, "_done_func"}, {2'd0, func64}, {2'd0, exp_f});
    chk({tag, "_done_busy"}, {6'd0, mb64, st64}, 8'd0);
  endtask

  initial begin
    #2;
    chk("reset64", {func64, ov64, st64}, 8'd0);
    chk("reset64_busy", {7'd0, mb64}, 8'd0);
    chk("reset32", {func32, ov32, st32}, 8'd0);
    #5 rst_n = 1'b1;

    // Back-to-back fast ops from the first edge after reset.
    in_valid = 1'b1;
    req(2'b10, 7'b0110011, 3'b000, 1'b1, 1'b0);
    tick();
    chk("sub_r", {func64, ov64, st64}, {6'b001000, 1'b1, 1'b0});
    req(2'b00, 7'b0000011, 3'b010, 1'b1, 1'b1);
    tick();
    chk("add_ls", {func64, ov64, st64}, {6'b000000, 1'b1, 1'b0});
    req(2'b01, 7'b0100011, 3'b000, 1'b0, 1'b0);
    tick();
    chk("sub_ls", {func64, ov64, st64}, {6'b001000, 1'b1, 1'b0});
    req(2'b11, 7'b1100011, 3'b110, 1'b0, 1'b0);
    tick();
    chk("br_110", {func64, ov64, st64}, {6'b001011, 1'b1, 1'b0});
    req(2'b11, 7'b1100011, 3'b101, 1'b0, 1'b0);
    tick();
    chk("br_101", {func64, ov64, st64}, {6'b001010, 1'b1, 1'b0});
    req(2'b11, 7'b1100011, 3'b011, 1'b1, 1'b1);
    tick();
    chk("br_011", {func64, ov64, st64}, {6'b001000, 1'b1, 1'b0});
    req(2'b10, 7'b0010011, 3'b001, 1'b0, 1'b1);
    tick();
    chk("opimm_b25", {func64, ov64, st64}, {6'b000001, 1'b1, 1'b0});
    req(2'b10, 7'b0011011, 3'b101, 1'b1, 1'b0);
    tick();
    chk("sraiw64", {func64, ov64, st64}, {6'b011101, 1'b1, 1'b0});
    in_valid = 1'b0;
    tick();
    chk("hold_func", {func64, ov64, st64}, {6'b011101, 1'b0, 1'b0});

    // DIVW, 64 cycles, request held during BUSY and DONE is ignored.
    req(2'b10, 7'b0111011, 3'b100, 1'b0, 1'b1);
    run_md("divw", 64, 6'b110100, 1'b1);
    tick();
    chk("done_ignored", {func64, ov64, st64}, {6'b110100, 1'b0, 1'b0});
    tick();
    chk("after_done", {func64, ov64, st64}, {6'b000000, 1'b1, 1'b0});
    in_valid = 1'b0;

    // MUL full run.
    req(2'b10, 7'b0110011, 3'b000, 1'b0, 1'b1);
    run_md("mul", 4, 6'b100000, 1'b0);
    tick();
    chk("mul_post", {7'd0, ov64}, 8'd0);

    // MUL flushed on its second BUSY cycle.
    req(2'b10, 7'b0110011, 3'b001, 1'b0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mulh_busy1", {6'd0, mb64, st64}, 8'd3);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", {5'd0, ov64, mb64, st64}, 8'd0);
    req(2'b01, 7'b0000000, 3'b000, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    chk("post_flush_req", {func64, ov64, st64}, {6'b001000, 1'b1, 1'b0});
    // Flush beats in_valid in IDLE.
    req(2'b00, 7'b0000000, 3'b000, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_prio", {func64, ov64, st64}, {6'b001000, 1'b0, 1'b0});

    // Async reset in the middle of a DIV.
    req(2'b10, 7'b0110011, 3'b100, 1'b0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("div_busy", {func64, mb64, st64}, {6'b100100, 1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {func64, ov64, st64}, 8'd0);
    chk("async_rst_busy", {7'd0, mb64}, 8'd0);
    #2 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (ov64 || st64) n++;
    end
    chk("no_valid_after_rst", 8'(n), 8'd0);

    // XLEN=32 instance: no word bit, no md for OP-32 opcode.
    req(2'b10, 7'b0011011, 3'b101, 1'b1, 1'b0);
    in_valid32 = 1'b1;
    tick();
    chk("x32_sraiw", {func32, ov32, st32}, {6'b001101, 1'b1, 1'b0});
    req(2'b10, 7'b0111011, 3'b100, 1'b0, 1'b1);
    tick();
    in_valid32 = 1'b0;
    chk("x32_divw", {func32, ov32, st32}, {6'b000100, 1'b1, 1'b0});
    chk("x32_busy", {7'd0, mb32}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
